// File: rtl/sum_accumulator.sv
// Block accumulator: gathers N_SAMPLES adder results, then holds total/avg/min/max
// until the downstream consumer takes them through a valid/ready handshake.
module sum_accumulator #(
  parameter int N_SAMPLES = 4,
  localparam int LW = $clog2(N_SAMPLES),
  localparam int TW = 5 + LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    sum_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] out_total,
  output logic [4:0]    out_avg,
  output logic [4:0]    out_min,
  output logic [4:0]    out_max,
  output logic [7:0]    blk_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t        state;
  logic [TW-1:0] total;
  logic [LW-1:0] cnt;
  logic [4:0]    mn;
  logic [4:0]    mx;

  logic          accept;
  logic          last;
  logic [TW-1:0] next_total;
  logic [4:0]    next_min;
  logic [4:0]    next_max;

  assign in_ready = (state == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == LW'(N_SAMPLES - 1));

  // The first sample of a block seeds min/max; later samples only replace on strict compare.
  always_comb begin
    next_total = total + {{LW{1'b0}}, sum_in};
    next_min   = mn;
    next_max   = mx;
    if (cnt == '0) begin
      next_min = sum_in;
      next_max = sum_in;
    end else begin
      if (sum_in < mn) next_min = sum_in;
      if (sum_in > mx) next_max = sum_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      total     <= '0;
      cnt       <= '0;
      mn        <= '0;
      mx        <= '0;
      out_valid <= 1'b0;
      out_total <= '0;
      out_avg   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      blk_count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              out_total <= next_total;
              out_avg   <= next_total[TW-1:LW];
              out_min   <= next_min;
              out_max   <= next_max;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
            total <= next_total;
            cnt   <= cnt + LW'(1);
            mn    <= next_min;
            mx    <= next_max;
          end
        end
        HOLD: begin
          // Running state is cleared here rather than at completion so HOLD is fully frozen.
          if (out_ready) begin
            out_valid <= 1'b0;
            blk_count <= blk_count + 8'd1;
            total     <= '0;
            cnt       <= '0;
            mn        <= '0;
            mx        <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator with N_SAMPLES=4 (TW=7).
module tb_sum_accumulator;

  logic       clk;
  logic       rst;
  logic [4:0] sum_in;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_total;
  logic [4:0] out_avg;
  logic [4:0] out_min;
  logic [4:0] out_max;
  logic [7:0] blk_count;

  int total;
  int bad;

  sum_accumulator #(.N_SAMPLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_avg   (out_avg),
    .out_min   (out_min),
    .out_max   (out_max),
    .blk_count (blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, so every check sits away from it.
  task automatic sendSample(input logic [4:0] d);
    in_valid = 1'b1;
    sum_in   = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
    sendSample(a);
    sendSample(b);
    sendSample(c);
    sendSample(d);
  endtask

  task automatic checkResult(input string tag, input int t, input int avg, input int mn, input int mx);
    checkOutput({tag, ".valid"}, 32'(out_valid), 1);
    checkOutput({tag, ".total"}, 32'(out_total), t);
    checkOutput({tag, ".avg"},   32'(out_avg), avg);
    checkOutput({tag, ".min"},   32'(out_min), mn);
    checkOutput({tag, ".max"},   32'(out_max), mx);
  endtask

  task automatic handshake(input string tag, input int expCount);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, ".validAfterHs"}, 32'(out_valid), 0);
    checkOutput({tag, ".blkCount"}, 32'(blk_count), expCount);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    sum_in    = 5'd0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.inReady",  32'(in_ready), 0);
    checkOutput("rst.outValid", 32'(out_valid), 0);
    checkOutput("rst.total",    32'(out_total), 0);
    checkOutput("rst.blkCount", 32'(blk_count), 0);
    rst = 1'b0;
    #1;
    checkOutput("postRst.inReady", 32'(in_ready), 1);

    // Basic block with out_ready held high throughout
    out_ready = 1'b1;
    applyStimulus(5'd6, 5'd7, 5'd8, 5'd9);
    checkResult("basic", 30, 7, 6, 9);
    checkOutput("basic.inReadyHold", 32'(in_ready), 0);
    checkOutput("basic.blkBefore", 32'(blk_count), 0);
    handshake("basic", 1);
    checkOutput("basic.totalKept", 32'(out_total), 30);
    checkOutput("basic.inReadyAfter", 32'(in_ready), 1);

    // Range extremes
    applyStimulus(5'd30, 5'd30, 5'd30, 5'd30);
    checkResult("max", 120, 30, 30, 30);
    handshake("max", 2);
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd1);
    checkResult("low", 1, 0, 0, 1);
    handshake("low", 3);

    // Backpressure: offered 15s during HOLD must be ignored
    applyStimulus(5'd1, 5'd2, 5'd3, 5'd4);
    in_valid = 1'b1;
    sum_in   = 5'd15;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp.inReady", 32'(in_ready), 0);
      checkResult("bp", 10, 2, 1, 4);
    end
    in_valid = 1'b0;
    handshake("bp", 4);
    applyStimulus(5'd1, 5'd1, 5'd1, 5'd1);
    checkResult("afterBp", 4, 1, 1, 1);
    handshake("afterBp", 5);

    // Reset in the middle of a block, asserted between clock edges
    sendSample(5'd5);
    sendSample(5'd5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRst.inReady",  32'(in_ready), 0);
    checkOutput("midRst.outValid", 32'(out_valid), 0);
    checkOutput("midRst.total",    32'(out_total), 0);
    checkOutput("midRst.avg",      32'(out_avg), 0);
    checkOutput("midRst.min",      32'(out_min), 0);
    checkOutput("midRst.max",      32'(out_max), 0);
    checkOutput("midRst.blkCount", 32'(blk_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(5'd2, 5'd2, 5'd2, 5'd2);
    checkResult("afterRst", 8, 2, 2, 2);
    handshake("afterRst", 1);

    // Sparse samples with idle gaps carrying junk data
    begin
      logic [4:0] vals [4];
      int gaps [4];
      vals = '{5'd3, 5'd9, 5'd1, 5'd4};
      gaps = '{0, 3, 1, 2};
      for (int i = 0; i < 4; i++) begin
        for (int g = 0; g < gaps[i]; g++) begin
          in_valid = 1'b0;
          sum_in   = 5'($urandom_range(0, 30));
          @(posedge clk);
          #1;
        end
        sendSample(vals[i]);
      end
    end
    checkResult("sparse", 17, 4, 1, 9);
    handshake("sparse", 2);

    // Wrap-around of the block counter after 256 handshakes
    for (int b = 2; b < 255; b++) begin
      applyStimulus(5'd1, 5'd2, 5'd3, 5'd4);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    checkOutput("wrap.blk255", 32'(blk_count), 255);
    applyStimulus(5'd1, 5'd2, 5'd3, 5'd4);
    handshake("wrap", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter: N_SAMPLES, 4, samples per block; legal values 2, 4, 8, 16 (power of two only).
REQ-002 Derived constant: TW = 5 + log2(N_SAMPLES), width of out_total.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: sum_in  input  5  unsigned result from the upstream 4-bit adder (range 0..30).
REQ-006 Port: in_valid  input  1  sum_in is valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts a sample this cycle.
REQ-008 Port: out_valid  output  1  block result is present on the out_* ports.
REQ-009 Port: out_ready  input  1  downstream accepts the block result.
REQ-010 Port: out_total  output  TW  sum of the N_SAMPLES samples in the block.
REQ-011 Port: out_avg  output  5  out_total >> log2(N_SAMPLES), truncated.
REQ-012 Port: out_min  output  5  smallest sample in the block.
REQ-013 Port: out_max  output  5  largest sample in the block.
REQ-014 Port: blk_count  output  8  number of completed output handshakes, modulo 256.

Function
REQ-015 The block SHALL implement a two-state FSM, ACCUM and HOLD.
REQ-016 in_ready SHALL be 1 exactly when the state is ACCUM and rst is low.
REQ-017 A sample SHALL be accepted at a rising edge where in_valid=1 and in_ready=1; no other edge accepts a sample.
REQ-018 On each accept, the block SHALL add the zero-extended sum_in to a TW-bit running total; TW bits SHALL guarantee no overflow.
REQ-019 On the first accept of a block, running min and max SHALL both load sum_in.
REQ-020 On later accepts, min SHALL update when sum_in < min and max SHALL update when sum_in > max; ties leave them unchanged.
REQ-021 A sample counter SHALL count accepts within the block, 0..N_SAMPLES-1.
REQ-022 On the N_SAMPLES-th accept, the block SHALL register the result (including that sample) into out_total, out_avg, out_min and out_max.
REQ-023 On that same edge, the block SHALL set out_valid=1 and enter HOLD, so out_valid is visible in the cycle after the last accept (latency 1).
REQ-024 In HOLD, the block SHALL ignore in_valid and sum_in, and all out_* ports SHALL remain stable.
REQ-025 A rising edge with out_valid=1 and out_ready=1 SHALL clear out_valid, increment blk_count (wrapping 255->0), clear the running total, counter, min and max, and enter ACCUM.
REQ-026 No sample SHALL be accepted on the handshake edge; the next block's first accept occurs no earlier than the following edge.
REQ-027 While out_valid=0, out_ready SHALL have no effect.
REQ-028 Cycles with in_valid=0 in ACCUM SHALL leave all state unchanged; gaps between samples are arbitrary.
REQ-029 After a handshake, out_total, out_avg, out_min and out_max SHALL keep the last block's values until the next block completes.

Reset
REQ-030 While rst=1, the block SHALL force state=ACCUM, the running total, counter, min and max to 0, and in_ready to 0.
REQ-031 While rst=1, the block SHALL force out_valid, out_total, out_avg, out_min, out_max and blk_count to 0.
REQ-032 Assertion of rst SHALL take effect immediately, independent of clk.
REQ-033 A partially accumulated block or a pending result SHALL be discarded on reset.
REQ-034 The first rising edge after rst falls SHALL be able to accept a sample.

Verification (N_SAMPLES=4)
REQ-035 Bench SHALL cover basic block: samples 6,7,8,9 on consecutive cycles, out_ready=1 -> out_total=30, out_avg=7, out_min=6, out_max=9, out_valid high one cycle, blk_count=1.
REQ-036 Bench SHALL cover the maximum range: samples 30,30,30,30 -> out_total=120, out_avg=30, out_min=out_max=30; samples 0,0,0,1 -> out_total=1, out_avg=0, out_min=0, out_max=1.
REQ-037 Bench SHALL cover backpressure: block 1,2,3,4 completes with out_ready=0 for 3 cycles while in_valid=1 and sum_in=15 -> in_ready=0, outputs hold total=10/min=1/max=4, and the 15s are not counted.
REQ-038 Bench SHALL cover reset mid-block: accept 5,5, assert rst asynchronously between edges, release, then send 2,2,2,2 -> out_total=8, blk_count=1, with all outputs 0 during reset.
REQ-039 Bench SHALL cover sparse input: samples 3,9,1,4 with 0-3 idle cycles between them -> out_total=17, out_avg=4, out_min=1, out_max=9.
REQ-040 Bench SHALL cover wrap-around: 256 complete blocks -> blk_count returns to 0.
